instr_fetch_stage: RTL and testbench

- Upstream neighbour of the decode stage. Keeps the PC and fetches 32-bit instructions from instruction memory over a req/ready handshake.
- Owns the IF/ID pipeline register. Its id_imm16 output drives the decode-stage sign extender directly.
- Handles decode stalls with a one-entry skid buffer, and EX-stage redirects (branch/jump) with a flush.

---
 rtl/instr_fetch_stage_pkg.sv | 22 ++
 rtl/instr_fetch_stage_if.sv | 13 +
 rtl/instr_fetch_stage_skid_buffer.sv | 45 ++++
 rtl/instr_fetch_stage.sv | 133 +++++++++++++
 tb/tb_instr_fetch_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage: NOP encoding,
// FSM state encoding, IF/ID entry layout and default reset PC.
package instr_fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } ifid_entry_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master)
// and instruction memory (slave).
interface instr_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ready, input imem_rdata);
    modport slave  (input  imem_req, input imem_addr,
                    output imem_ready, output imem_rdata);
endinterface

// File: rtl/instr_fetch_stage_skid_buffer.sv
// One-entry skid buffer holding a fetched instruction and its PC+4 while
// decode is stalled. Clear wins over load, load wins over unload.
module fetch_skid_buffer
    import instr_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  ifid_entry_t din,
    output logic        valid,
    output ifid_entry_t dout
);

    logic        valid_q, valid_d;
    ifid_entry_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, fetch FSM and IF/ID register with skid buffer and redirect.
// Optional macro DELAY_SLOT_EN keeps a valid IF/ID instruction across a redirect.
//
// state | meaning
// FETCH | request issued every cycle at pc; transfers go to IF/ID or skid
// HOLD  | skid holds a word, no request until IF/ID accepts it
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic                       clk,
    input  logic                       rst,
    instr_fetch_stage_if.master        imem,
    input  logic                       id_stall,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       id_valid,
    output logic [31:0]                id_instr,
    output logic [31:0]                id_pc_plus4,
    output logic [15:0]                id_imm16
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc_plus4_q, id_pc_plus4_d;

    logic         skid_load, skid_unload, skid_clear, skid_valid;
    ifid_entry_t  skid_din, skid_dout;
    logic         transfer, accept;
    logic [31:0]  pc_plus4;
    logic         unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    // Request is gated by rst so a reset abandons any outstanding request.
    assign imem.imem_req  = (state_q == FETCH) && !rst;
    assign imem.imem_addr = pc_q;

    assign transfer = imem.imem_req && imem.imem_ready;
    assign accept   = !id_valid_q || !id_stall;
    assign pc_plus4 = pc_inc(pc_q);
    assign skid_din = '{instr: imem.imem_rdata, pc_plus4: pc_plus4};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;
        skid_clear    = 1'b0;

        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            state_d    = FETCH;
            skid_clear = 1'b1;
`ifdef DELAY_SLOT_EN
            // The delay-slot instruction leaves IF/ID only when decode takes it.
            if (accept) begin
                id_valid_d = 1'b0;
            end
`else
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
`endif
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (transfer) begin
                        pc_d = pc_plus4;
                        if (accept) begin
                            id_valid_d    = 1'b1;
                            id_instr_d    = imem.imem_rdata;
                            id_pc_plus4_d = pc_plus4;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end else if (accept) begin
                        id_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        id_valid_d    = 1'b1;
                        id_instr_d    = skid_dout.instr;
                        id_pc_plus4_d = skid_dout.pc_plus4;
                        skid_unload   = 1'b1;
                        state_d       = FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_plus4_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (skid_clear),
        .din    (skid_din),
        .valid  (skid_valid),
        .dout   (skid_dout)
    );

    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_imm16    = id_instr_q[15:0];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: two instances (RESET_PC 0 and FFFF_FFF8) share
// stimulus; an occupancy-based model is compared every cycle, plus literal checks.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h5A5A};
    endfunction

    function automatic logic [31:0] reset_pc_of(input int k);
        return (k == 1) ? 32'hFFFF_FFF8 : 32'h0000_0000;
    endfunction

    instr_fetch_stage_if if0 ();
    instr_fetch_stage_if if1 ();

    assign if0.imem_ready = ready;
    assign if1.imem_ready = ready;
    assign if0.imem_rdata = memf(if0.imem_addr);
    assign if1.imem_rdata = memf(if1.imem_addr);

    logic        o_req   [2];
    logic [31:0] o_addr  [2];
    logic        o_valid [2];
    logic [31:0] o_instr [2];
    logic [31:0] o_pc4   [2];
    logic [15:0] o_imm   [2];

    assign o_req[0]  = if0.imem_req;
    assign o_addr[0] = if0.imem_addr;
    assign o_req[1]  = if1.imem_req;
    assign o_addr[1] = if1.imem_addr;

    instr_fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .imem(if0), .id_stall(stall),
        .redirect_valid(redir), .redirect_pc(rpc),
        .id_valid(o_valid[0]), .id_instr(o_instr[0]),
        .id_pc_plus4(o_pc4[0]), .id_imm16(o_imm[0])
    );

    instr_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst(rst), .imem(if1), .id_stall(stall),
        .redirect_valid(redir), .redirect_pc(rpc),
        .id_valid(o_valid[1]), .id_instr(o_instr[1]),
        .id_pc_plus4(o_pc4[1]), .id_imm16(o_imm[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: pc, IF/ID contents and skid occupancy; requests only when skid empty.
    logic [31:0] m_pc    [2];
    logic        m_valid [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_pc4   [2];
    int          m_skid_n[2];
    logic [63:0] m_skid_d[2];

    task automatic model_step(input int k);
        logic [31:0] rd;
        bit acc;
        if (rst) begin
            m_pc[k] = reset_pc_of(k);
            m_valid[k] = 1'b0;
            m_instr[k] = 32'h0;
            m_pc4[k] = 32'h0;
            m_skid_n[k] = 0;
        end else begin
            rd  = memf(m_pc[k]);
            acc = !m_valid[k] || !stall;
            if (redir) begin
                m_pc[k] = {rpc[31:2], 2'b00};
                m_skid_n[k] = 0;
`ifdef DELAY_SLOT_EN
                if (acc) m_valid[k] = 1'b0;
`else
                m_valid[k] = 1'b0;
                m_instr[k] = 32'h0;
`endif
            end else if (m_skid_n[k] == 0) begin
                if (ready) begin
                    if (acc) begin
                        m_instr[k] = rd;
                        m_pc4[k] = m_pc[k] + 32'd4;
                        m_valid[k] = 1'b1;
                    end else begin
                        m_skid_d[k] = {rd, m_pc[k] + 32'd4};
                        m_skid_n[k] = 1;
                    end
                    m_pc[k] = m_pc[k] + 32'd4;
                end else if (acc) begin
                    m_valid[k] = 1'b0;
                end
            end else if (acc) begin
                {m_instr[k], m_pc4[k]} = m_skid_d[k];
                m_valid[k] = 1'b1;
                m_skid_n[k] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dut%0d.req", k),   {31'b0, o_req[k]},
                    {31'b0, (!rst && m_skid_n[k] == 0)});
                chk($sformatf("dut%0d.addr", k),  o_addr[k], m_pc[k]);
                chk($sformatf("dut%0d.valid", k), {31'b0, o_valid[k]}, {31'b0, m_valid[k]});
                chk($sformatf("dut%0d.instr", k), o_instr[k], m_instr[k]);
                chk($sformatf("dut%0d.pc4", k),   o_pc4[k], m_pc4[k]);
                chk($sformatf("dut%0d.imm16", k), {16'b0, o_imm[k]}, {16'b0, m_instr[k][15:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst.valid", {31'b0, o_valid[0]}, 32'd0);
        chk("rst.instr", o_instr[0], 32'h0);
        chk("rst.pc4",   o_pc4[0], 32'h0);
        chk("rst.req",   {31'b0, o_req[0]}, 32'd1);
        chk("seq.addr0", o_addr[0], 32'h0);
        chk("wrap.addr0", o_addr[1], 32'hFFFF_FFF8);

        tick(); #1;
        chk("seq.addr4",  o_addr[0], 32'h4);
        chk("seq.valid",  {31'b0, o_valid[0]}, 32'd1);
        chk("seq.pc4_4",  o_pc4[0], 32'h4);
        chk("seq.imm16",  {16'b0, o_imm[0]}, 32'h0000_5A5A);
        chk("wrap.addr1", o_addr[1], 32'hFFFF_FFFC);
        chk("wrap.pc4_1", o_pc4[1], 32'hFFFF_FFFC);

        tick(); #1;
        chk("seq.addr8",  o_addr[0], 32'h8);
        chk("seq.pc4_8",  o_pc4[0], 32'h8);
        chk("wrap.addr2", o_addr[1], 32'h0);
        chk("wrap.pc4_2", o_pc4[1], 32'h0);

        ready = 1'b0; #1;
        chk("wait.req", {31'b0, o_req[0]}, 32'd1);
        repeat (3) begin
            tick(); #1;
            chk("wait.addr",  o_addr[0], 32'h8);
            chk("wait.valid", {31'b0, o_valid[0]}, 32'd0);
        end
        ready = 1'b1;
        tick(); #1;
        chk("wait.done.valid", {31'b0, o_valid[0]}, 32'd1);
        chk("wait.done.instr", o_instr[0], memf(32'h8));
        chk("wait.done.pc4",   o_pc4[0], 32'hC);
        chk("wait.done.addr",  o_addr[0], 32'hC);

        stall = 1'b1;
        repeat (4) begin
            tick(); #1;
            chk("stall.req",   {31'b0, o_req[0]}, 32'd0);
            chk("stall.addr",  o_addr[0], 32'h10);
            chk("stall.pc4",   o_pc4[0], 32'hC);
            chk("stall.instr", o_instr[0], memf(32'h8));
        end
        stall = 1'b0;
        tick(); #1;
        chk("skid.pc4",   o_pc4[0], 32'h10);
        chk("skid.instr", o_instr[0], memf(32'hC));
        chk("skid.req",   {31'b0, o_req[0]}, 32'd1);
        tick(); #1;
        chk("after.pc4",  o_pc4[0], 32'h14);
        chk("after.addr", o_addr[0], 32'h14);

        redir = 1'b1; rpc = 32'h0000_0103; #1;
        chk("redir.req", {31'b0, o_req[0]}, 32'd1);
        tick(); redir = 1'b0; #1;
        chk("redir.addr",  o_addr[0], 32'h100);
        chk("redir.valid", {31'b0, o_valid[0]}, 32'd0);
`ifdef DELAY_SLOT_EN
        chk("redir.instr", o_instr[0], memf(32'h10));
`else
        chk("redir.instr", o_instr[0], 32'h0);
`endif
        tick(); #1;
        chk("redir.next.pc4",   o_pc4[0], 32'h104);
        chk("redir.next.instr", o_instr[0], memf(32'h100));

        stall = 1'b1; redir = 1'b1; rpc = 32'h0000_0200;
        tick(); redir = 1'b0; stall = 1'b0; #1;
        chk("redir2.addr", o_addr[0], 32'h200);
`ifdef DELAY_SLOT_EN
        chk("redir2.valid", {31'b0, o_valid[0]}, 32'd1);
        chk("redir2.instr", o_instr[0], memf(32'h100));
        chk("redir2.pc4",   o_pc4[0], 32'h104);
`else
        chk("redir2.valid", {31'b0, o_valid[0]}, 32'd0);
        chk("redir2.instr", o_instr[0], 32'h0);
`endif
        tick(); #1;
        chk("redir2.next.pc4", o_pc4[0], 32'h204);

        stall = 1'b1;
        tick(); #1;
        chk("hold.req",  {31'b0, o_req[0]}, 32'd0);
        chk("hold.addr", o_addr[0], 32'h208);
        rst = 1'b1; #1;
        chk("rsthold.req", {31'b0, o_req[0]}, 32'd0);
        tick(); rst = 1'b0; stall = 1'b0; #1;
        chk("rsthold.valid", {31'b0, o_valid[0]}, 32'd0);
        chk("rsthold.addr",  o_addr[0], 32'h0);
        chk("rsthold.req",   {31'b0, o_req[0]}, 32'd1);
        tick(); #1;
        chk("rsthold.pc4",   o_pc4[0], 32'h4);
        chk("rsthold.instr", o_instr[0], memf(32'h0));

        repeat (3) tick();
        @(posedge clk); #7;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
